imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate extender.
- Extracts and extends the immediate of a 32-bit RV instruction to XLEN bits. Covers all base formats plus CSR zimm and shift amount.
- Format comes from an explicit selector or from opcode decode.
- Sits between fetch/decode and execute. Valid/ready handshake on both sides, a 2-entry skid buffer, and a saturating illegal-format counter.

---
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_imm_gen_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode (master) and the immediate generator (slave).
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic [2:0]       out_fmt;
    logic             fmt_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  en, in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm, out_fmt, fmt_illegal, illegal_cnt
    );

    modport master (
        output en, in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm, out_fmt, fmt_illegal, illegal_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: one-cycle latency, 2-entry skid buffer,
// saturating counter of accepted entries whose format was reserved/undecodable.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] F_I   = 3'd0;
    localparam logic [2:0] F_S   = 3'd1;
    localparam logic [2:0] F_B   = 3'd2;
    localparam logic [2:0] F_J   = 3'd3;
    localparam logic [2:0] F_U   = 3'd4;
    localparam logic [2:0] F_Z   = 3'd5;
    localparam logic [2:0] F_SH  = 3'd6;
    localparam logic [2:0] F_ILL = 3'd7;

    // The immediate is fully formed at the input so the buffer holds results.
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } ent_t;

    ent_t             main_q, skid_q, ent_d;
    logic             main_vld_q, skid_vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       fmt_d;
    logic [XLEN-1:0]  imm_d;
    logic             in_xfer, out_xfer;

    wire [31:0] ins = bus.instr;

    // Format select: explicit selector, or opcode/funct3 decode when AUTO_DECODE.
    always_comb begin
        fmt_d = F_ILL;
        if (AUTO_DECODE) begin
            case (ins[6:0])
                7'b0000011, 7'b1100111: fmt_d = F_I;
                7'b0010011: fmt_d = (ins[13:12] == 2'b01) ? F_SH : F_I;
                7'b0100011: fmt_d = F_S;
                7'b1100011: fmt_d = F_B;
                7'b1101111: fmt_d = F_J;
                7'b0110111, 7'b0010111: fmt_d = F_U;
                7'b1110011: fmt_d = ins[14] ? F_Z : F_I;
                default:    fmt_d = F_ILL;
            endcase
        end else begin
            fmt_d = bus.imm_src;
        end
    end

    // Immediate extraction; signed casts sign-extend from instr[31] to XLEN.
    always_comb begin
        imm_d = '0;
        case (fmt_d)
            F_I:  imm_d = XLEN'($signed(ins[31:20]));
            F_S:  imm_d = XLEN'($signed({ins[31:25], ins[11:7]}));
            F_B:  imm_d = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            F_J:  imm_d = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            F_U:  imm_d = XLEN'($signed({ins[31:12], 12'b0}));
            F_Z:  imm_d = XLEN'(ins[19:15]);
            F_SH: imm_d = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            default: imm_d = '0;
        endcase
        ent_d = '{imm: imm_d, fmt: fmt_d, ill: (fmt_d == F_ILL)};
    end

    // Skid full implies main full, so in_ready only has to watch the skid slot.
    assign in_xfer  = bus.en & bus.in_valid & ~skid_vld_q;
    assign out_xfer = bus.en & main_vld_q & bus.out_ready;

    assign bus.in_ready    = bus.en & ~skid_vld_q;
    assign bus.out_valid   = bus.en & main_vld_q;
    assign bus.imm         = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.fmt_illegal = main_q.ill;
    assign bus.illegal_cnt = cnt_q;

    // Buffer update: skid advances to main on output transfer; FIFO order kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else if (out_xfer) begin
            if (skid_vld_q) begin
                main_q     <= skid_q;
                skid_vld_q <= 1'b0;
            end else if (in_xfer) begin
                main_q     <= ent_d;
            end else begin
                main_vld_q <= 1'b0;
            end
        end else if (in_xfer) begin
            if (main_vld_q) begin
                skid_q     <= ent_d;
                skid_vld_q <= 1'b1;
            end else begin
                main_q     <= ent_d;
                main_vld_q <= 1'b1;
            end
        end
    end

    // Saturating count of accepted illegal entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_xfer && ent_d.ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: dut_a is XLEN=32 / explicit selector / 4-bit counter,
// dut_b is XLEN=64 / opcode decode.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .CNT_W(4))  ifa ();
    imm_gen_pipe_if #(.XLEN(64), .CNT_W(16)) ifb ();

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word to dut_a with out_ready=1, then check it one edge later.
    task automatic a_pipe(input string tag, input logic [2:0] src, input logic [31:0] ins,
                          input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
        ifa.in_valid  = 1'b1;
        ifa.out_ready = 1'b1;
        ifa.imm_src   = src;
        ifa.instr     = ins;
        tick();
        chk({tag, "_vld"}, 64'(ifa.out_valid), 64'd1);
        chk({tag, "_imm"}, 64'(ifa.imm), 64'(eimm));
        chk({tag, "_fmt"}, 64'(ifa.out_fmt), 64'(efmt));
        chk({tag, "_ill"}, 64'(ifa.fmt_illegal), 64'(eill));
    endtask

    // Same for dut_b; imm_src is held at 111 to show it is ignored in decode mode.
    task automatic b_pipe(input string tag, input logic [31:0] ins,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
        ifb.in_valid  = 1'b1;
        ifb.out_ready = 1'b1;
        ifb.imm_src   = 3'b111;
        ifb.instr     = ins;
        tick();
        chk({tag, "_vld"}, 64'(ifb.out_valid), 64'd1);
        chk({tag, "_imm"}, ifb.imm, eimm);
        chk({tag, "_fmt"}, 64'(ifb.out_fmt), 64'(efmt));
        chk({tag, "_ill"}, 64'(ifb.fmt_illegal), 64'(eill));
    endtask

    initial begin
        ifa.en = 1'b1; ifa.in_valid = 1'b0; ifa.instr = '0; ifa.imm_src = '0; ifa.out_ready = 1'b0;
        ifb.en = 1'b1; ifb.in_valid = 1'b0; ifb.instr = '0; ifb.imm_src = '0; ifb.out_ready = 1'b0;
        #2;
        chk("rst_vld", 64'(ifa.out_valid), 64'd0);
        chk("rst_imm", 64'(ifa.imm), 64'd0);
        chk("rst_fmt", 64'(ifa.out_fmt), 64'd0);
        chk("rst_ill", 64'(ifa.fmt_illegal), 64'd0);
        chk("rst_cnt", 64'(ifa.illegal_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 64'(ifa.in_ready), 64'd1);

        // Back-to-back, one word per cycle, every format.
        a_pipe("I",   3'b000, 32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0);
        a_pipe("B",   3'b010, 32'hFE000EE3, 32'hFFFFFFFC, 3'b010, 1'b0);
        a_pipe("U",   3'b100, 32'h123450B7, 32'h12345000, 3'b100, 1'b0);
        a_pipe("S",   3'b001, 32'hFE112E23, 32'hFFFFFFFC, 3'b001, 1'b0);
        a_pipe("J",   3'b011, 32'h0080006F, 32'h00000008, 3'b011, 1'b0);
        a_pipe("Z",   3'b101, 32'h000F8073, 32'h0000001F, 3'b101, 1'b0);
        a_pipe("SH",  3'b110, 32'h03F09093, 32'h0000001F, 3'b110, 1'b0);
        a_pipe("ILL", 3'b111, 32'hFFFFFFFF, 32'h00000000, 3'b111, 1'b1);
        chk("cnt1", 64'(ifa.illegal_cnt), 64'd1);
        ifa.in_valid = 1'b0;
        tick();
        chk("drain_vld", 64'(ifa.out_valid), 64'd0);

        // Backpressure: A and B fill both entries, C must wait.
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.imm_src = 3'b000;
        ifa.instr = 32'h00100093;
        tick();
        chk("bp_rdyA", 64'(ifa.in_ready), 64'd1);
        ifa.instr = 32'h00200093;
        tick();
        chk("bp_rdyB", 64'(ifa.in_ready), 64'd0);
        ifa.instr = 32'h00300093;
        tick();
        chk("bp_hold_vld", 64'(ifa.out_valid), 64'd1);
        chk("bp_hold_imm", 64'(ifa.imm), 64'd1);
        ifa.out_ready = 1'b1;
        tick();
        chk("bp_B", 64'(ifa.imm), 64'd2);
        chk("bp_rdy2", 64'(ifa.in_ready), 64'd1);
        tick();
        chk("bp_C", 64'(ifa.imm), 64'd3);
        ifa.in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(ifa.out_valid), 64'd0);

        // en=0 freezes a held entry; it reappears unchanged.
        ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.instr = 32'h7FF00093;
        tick();
        ifa.en = 1'b0; ifa.out_ready = 1'b1; ifa.instr = 32'h00500093;
        #1;
        chk("en0_vld", 64'(ifa.out_valid), 64'd0);
        chk("en0_rdy", 64'(ifa.in_ready), 64'd0);
        tick(); tick();
        chk("en0_vld2", 64'(ifa.out_valid), 64'd0);
        ifa.in_valid = 1'b0; ifa.en = 1'b1;
        #1;
        chk("en1_vld", 64'(ifa.out_valid), 64'd1);
        chk("en1_imm", 64'(ifa.imm), 64'h7FF);
        tick();
        chk("en1_drain", 64'(ifa.out_valid), 64'd0);

        // Saturation: counter already at 1; 13 more gives E, 17 total stays at F.
        ifa.in_valid = 1'b1; ifa.out_ready = 1'b1; ifa.imm_src = 3'b111;
        for (int i = 0; i < 13; i++) tick();
        chk("cnt_e", 64'(ifa.illegal_cnt), 64'hE);
        for (int i = 0; i < 4; i++) tick();
        chk("cnt_sat", 64'(ifa.illegal_cnt), 64'hF);

        // Reset with both entries full.
        ifa.out_ready = 1'b0; ifa.imm_src = 3'b000;
        tick(); tick();
        chk("full_rdy", 64'(ifa.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_vld", 64'(ifa.out_valid), 64'd0);
        chk("mrst_cnt", 64'(ifa.illegal_cnt), 64'd0);
        ifa.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_rdy", 64'(ifa.in_ready), 64'd1);
        tick();
        chk("mrst_empty", 64'(ifa.out_valid), 64'd0);

        // XLEN=64 with opcode decode.
        b_pipe("bU",   32'h80000037, 64'hFFFFFFFF80000000, 3'b100, 1'b0);
        b_pipe("bSH",  32'h00309093, 64'd3, 3'b110, 1'b0);
        b_pipe("bSH6", 32'h03F09093, 64'h3F, 3'b110, 1'b0);
        b_pipe("bI",   32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0);
        b_pipe("bZ",   32'h000FD073, 64'h1F, 3'b101, 1'b0);
        b_pipe("bILL", 32'h00000000, 64'd0, 3'b111, 1'b1);
        chk("b_cnt", 64'(ifb.illegal_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
